player_sprite_render: RTL and testbench

Downstream consumer of the player sprite ROM (`player`). It takes raw VGA pixel coordinates and the player's game position, and generates sprite-relative row/col addresses for the ROM. It then composites the ROM's 12-bit colour over the background pixel and emits the final RGB with sync signals delay-matched. It sits between the VGA sync generator/background path and the DAC output registers.

---
 rtl/player_sprite_render_pkg.sv | 30 +++
 rtl/player_sprite_render_player.sv | 29 ++
 rtl/player_sprite_render.sv | 163 ++++++++++++++++
 tb/tb_player_sprite_render.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_sprite_render_pkg.sv
// Constants shared by the player renderer, the game logic and the other sprite renderers.
package player_sprite_render_pkg;

    localparam int unsigned COLOR_W      = 12;
    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned SCREEN_H     = 480;

    localparam int unsigned SPR_W        = 64;
    localparam int unsigned SPR_H        = 64;
    localparam int unsigned ROM_COL_AW   = 6;
    localparam int unsigned ROM_ROW_AW   = 6;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F;

    localparam int unsigned FLASH_FRAMES = 30;
    localparam int unsigned BLINK_SHIFT  = 2;

    typedef logic [COLOR_W-1:0] color_t;

    // Everything that travels alongside the ROM's address registers.
    typedef struct packed {
        logic   in_box;
        logic   video_on;
        logic   hsync;
        logic   vsync;
        logic   hide;
        color_t bg;
    } stage1_t;

endpackage

// File: rtl/player_sprite_render_player.sv
// Player sprite ROM: 64x64 texels, 12-bit colour, address registered internally.
module player
    import player_sprite_render_pkg::*;
(
    input  logic                  clk,
    input  logic [ROM_ROW_AW-1:0] row,
    input  logic [ROM_COL_AW-1:0] col,
    output logic [COLOR_W-1:0]    color_data
);

    logic [ROM_ROW_AW-1:0] row_q;
    logic [ROM_COL_AW-1:0] col_q;

    // Register the address; the texel appears one clock later.
    always_ff @(posedge clk) begin
        row_q <= row;
        col_q <= col;
    end

    // Texel contents: a diagonal see-through stripe over a row/col gradient.
    always_comb begin
        if (row_q[3:0] == col_q[3:0]) begin
            color_data = TRANSPARENT;
        end else begin
            color_data = {row_q[5:2], col_q[5:2], row_q[1:0], col_q[1:0]};
        end
    end

endmodule

// File: rtl/player_sprite_render.sv
// Player sprite compositor: address generation with mirroring and edge clipping,
// hit-flash blinking and a 2-stage pipeline that keeps rgb and syncs aligned.
module player_sprite_render
    import player_sprite_render_pkg::*;
#(
    parameter int unsigned SPR_W        = player_sprite_render_pkg::SPR_W,
    parameter int unsigned SPR_H        = player_sprite_render_pkg::SPR_H,
    parameter int unsigned FLASH_FRAMES = player_sprite_render_pkg::FLASH_FRAMES,
    parameter int unsigned BLINK_SHIFT  = player_sprite_render_pkg::BLINK_SHIFT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [9:0]   pixel_x,
    input  logic [9:0]   pixel_y,
    input  logic         video_on,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic         frame_tick,
    input  logic [11:0]  bg_rgb,
    input  logic [9:0]   player_x,
    input  logic [9:0]   player_y,
    input  logic         facing,
    input  logic         hit_pulse,
    output logic [11:0]  rgb,
    output logic         hsync_out,
    output logic         vsync_out,
    output logic         sprite_px,
    output logic         flashing
);

    localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);

    // Frame-latched position and facing
    logic [9:0]              pos_x_q, pos_x_d;
    logic [9:0]              pos_y_q, pos_y_d;
    logic                    face_q, face_d;

    // Hit flash
    logic [FW-1:0]           flash_cnt_q, flash_cnt_d;
    logic                    flashing_q, flashing_d;
    logic                    hide;

    // Address generation
    logic                    in_box;
    logic [ROM_COL_AW-1:0]   rel_col;
    logic [ROM_ROW_AW-1:0]   rel_row;
    logic [ROM_COL_AW-1:0]   rom_col;
    logic [ROM_ROW_AW-1:0]   rom_row;
    color_t                  color_data;

    // Pipeline
    stage1_t                 s1_q, s1_d;
    color_t                  rgb_q, rgb_d;
    logic                    sprite_px_q, sprite_px_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    opaque;

    // Position latch and flash counter; a hit reload beats a coincident frame decrement.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        face_d  = face_q;
        if (frame_tick) begin
            pos_x_d = player_x;
            pos_y_d = player_y;
            face_d  = facing;
        end

        flash_cnt_d = flash_cnt_q;
        if (hit_pulse) begin
            flash_cnt_d = FW'(FLASH_FRAMES);
        end else if (frame_tick && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - 1'b1;
        end
        flashing_d = (flash_cnt_d != '0);

        hide = (flash_cnt_q != '0) && flash_cnt_q[BLINK_SHIFT];
    end

    // Sprite-relative ROM address; only the low address bits of the difference matter,
    // so the subtraction is done at ROM width. 11-bit bounds keep edge sprites from wrapping.
    always_comb begin
        in_box = ({1'b0, pixel_x} >= {1'b0, pos_x_q}) &&
                 ({1'b0, pixel_x} <  ({1'b0, pos_x_q} + 11'(SPR_W))) &&
                 ({1'b0, pixel_y} >= {1'b0, pos_y_q}) &&
                 ({1'b0, pixel_y} <  ({1'b0, pos_y_q} + 11'(SPR_H)));

        rel_col = pixel_x[ROM_COL_AW-1:0] - pos_x_q[ROM_COL_AW-1:0];
        rel_row = pixel_y[ROM_ROW_AW-1:0] - pos_y_q[ROM_ROW_AW-1:0];

        rom_col = '0;
        rom_row = '0;
        if (in_box) begin
            rom_col = face_q ? (ROM_COL_AW'(SPR_W - 1) - rel_col) : rel_col;
            rom_row = rel_row;
        end
    end

    player u_rom (
        .clk        (clk),
        .row        (rom_row),
        .col        (rom_col),
        .color_data (color_data)
    );

    // Stage 1 capture and stage 2 compositing.
    always_comb begin
        s1_d.in_box   = in_box;
        s1_d.video_on = video_on;
        s1_d.hsync    = hsync_in;
        s1_d.vsync    = vsync_in;
        s1_d.hide     = hide;
        s1_d.bg       = bg_rgb;

        opaque = s1_q.in_box && (color_data != TRANSPARENT) && !s1_q.hide;

        if (!s1_q.video_on) begin
            rgb_d = '0;
        end else if (opaque) begin
            rgb_d = color_data;
        end else begin
            rgb_d = s1_q.bg;
        end
        sprite_px_d = s1_q.video_on && opaque;
        hsync_d     = s1_q.hsync;
        vsync_d     = s1_q.vsync;
    end

    // All state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            face_q      <= 1'b0;
            flash_cnt_q <= '0;
            flashing_q  <= 1'b0;
            s1_q        <= '0;
            rgb_q       <= '0;
            sprite_px_q <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            face_q      <= face_d;
            flash_cnt_q <= flash_cnt_d;
            flashing_q  <= flashing_d;
            s1_q        <= s1_d;
            rgb_q       <= rgb_d;
            sprite_px_q <= sprite_px_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign rgb       = rgb_q;
    assign sprite_px = sprite_px_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign flashing  = flashing_q;

endmodule

// File: tb/tb_player_sprite_render.sv
// Bench for player_sprite_render: behavioural model checked every cycle, plus literal probes.
module tb_player_sprite_render;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, hsync_in, vsync_in, frame_tick;
    logic [11:0] bg_rgb;
    logic [9:0]  player_x, player_y;
    logic        facing, hit_pulse;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, sprite_px, flashing;

    int n_checks = 0;
    int n_fail   = 0;

    player_sprite_render dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_tick (frame_tick),
        .bg_rgb     (bg_rgb),
        .player_x   (player_x),
        .player_y   (player_y),
        .facing     (facing),
        .hit_pulse  (hit_pulse),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .sprite_px  (sprite_px),
        .flashing   (flashing)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sprite artwork as arithmetic on the texel coordinates.
    function automatic int texel(input int r, input int c);
        if ((r % 16) == (c % 16)) return 'hF0F;
        return (r / 4) * 256 + (c / 4) * 16 + (r % 4) * 4 + (c % 4);
    endfunction

    // ---------------- behavioural model ----------------
    int m_pos_x = 0, m_pos_y = 0, m_face = 0, m_cnt = 0;
    int p_rgb = 0, p_spx = 0, p_hs = 0, p_vs = 0;
    int e_rgb = 0, e_spx = 0, e_hs = 0, e_vs = 0, e_flash = 0;
    bit model_ready = 0;

    always @(posedge clk) begin
        int px, py, rc, rr, col, opq, hid;
        // outputs after this edge are the pixel captured on the previous edge
        if (reset) begin
            e_rgb = 0; e_spx = 0; e_hs = 0; e_vs = 0;
        end else begin
            e_rgb = p_rgb; e_spx = p_spx; e_hs = p_hs; e_vs = p_vs;
        end
        // pixel presented now, judged against pre-edge state
        if (reset) begin
            p_rgb = 0; p_spx = 0; p_hs = 0; p_vs = 0;
        end else begin
            px  = int'(pixel_x);
            py  = int'(pixel_y);
            hid = (m_cnt != 0) && (((m_cnt / 4) % 2) == 1);
            opq = 0;
            col = 0;
            if (px >= m_pos_x && px < m_pos_x + 64 && py >= m_pos_y && py < m_pos_y + 64) begin
                rc  = px - m_pos_x;
                rr  = py - m_pos_y;
                if (m_face != 0) rc = 63 - rc;
                col = texel(rr, rc);
                opq = (col != 'hF0F) && !hid;
            end
            if (!video_on) p_rgb = 0;
            else if (opq != 0) p_rgb = col;
            else p_rgb = int'(bg_rgb);
            p_spx = (video_on && opq != 0) ? 1 : 0;
            p_hs  = int'(hsync_in);
            p_vs  = int'(vsync_in);
        end
        // state update
        if (reset) begin
            m_pos_x = 0; m_pos_y = 0; m_face = 0; m_cnt = 0;
        end else begin
            if (frame_tick) begin
                m_pos_x = int'(player_x); m_pos_y = int'(player_y); m_face = int'(facing);
            end
            if (hit_pulse) m_cnt = 30;
            else if (frame_tick && m_cnt > 0) m_cnt = m_cnt - 1;
        end
        e_flash = (m_cnt != 0) ? 1 : 0;
        model_ready = 1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ready) begin
            check("rgb",       int'(rgb),       e_rgb);
            check("sprite_px", int'(sprite_px), e_spx);
            check("hsync_out", int'(hsync_out), e_hs);
            check("vsync_out", int'(vsync_out), e_vs);
            check("flashing",  int'(flashing),  e_flash);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_px(input int x, input int y, input int bg, input bit vid);
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        bg_rgb     = 12'(bg);
        video_on   = vid;
        frame_tick = 1'b0;
        hit_pulse  = 1'b0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic place(input int x, input int y, input bit f);
        player_x = 10'(x);
        player_y = 10'(y);
        facing   = f;
        do_tick();
    endtask

    // Drive one pixel, wait the two-clock latency, check literal expectations.
    task automatic probe(input string nm, input int x, input int y, input int bg,
                         input bit vid, input int exp_rgb, input int exp_spx);
        set_px(x, y, bg, vid);
        cyc();
        cyc();
        check({nm, ".rgb"}, int'(rgb), exp_rgb);
        check({nm, ".spx"}, int'(sprite_px), exp_spx);
    endtask

    initial begin
        int flash_ticks;
        reset = 1'b1;
        set_px(0, 0, 0, 1'b0);
        hsync_in = 1'b0; vsync_in = 1'b0;
        player_x = '0; player_y = '0; facing = 1'b0;

        // 1: reset with random inputs, then 2-cycle latency from release
        for (int i = 0; i < 3; i++) begin
            pixel_x  = 10'($urandom); pixel_y = 10'($urandom);
            bg_rgb   = 12'($urandom); video_on = 1'($urandom);
            hsync_in = 1'($urandom);  vsync_in = 1'($urandom);
            hit_pulse = 1'($urandom); frame_tick = 1'($urandom);
            cyc();
        end
        check("reset.rgb", int'(rgb), 0);
        check("reset.flashing", int'(flashing), 0);
        set_px(300, 300, 'hABC, 1'b1);
        hsync_in = 1'b1; vsync_in = 1'b0;
        reset = 1'b0;
        cyc();
        check("latency1.rgb", int'(rgb), 0);
        cyc();
        check("latency2.rgb", int'(rgb), 'hABC);
        check("latency2.hsync", int'(hsync_out), 1);

        // 2: sprite at (100,50) facing right
        place(100, 50, 1'b0);
        for (int x = 90; x < 172; x++) begin
            set_px(x, 60, int'($urandom_range(0, 4095)), 1'b1);
            cyc();
        end
        probe("r_left",  100, 60, 'h456, 1'b1, 'h208, 1);
        probe("r_in",    103, 60, 'h456, 1'b1, 'h20B, 1);
        probe("r_right", 163, 60, 'h456, 1'b1, 'h2FB, 1);
        probe("r_pre",    99, 60, 'h456, 1'b1, 'h456, 0);
        probe("r_post",  164, 60, 'h456, 1'b1, 'h456, 0);
        probe("blank",   103, 60, 'h456, 1'b0, 0, 0);
        // 4: transparent texel shows background
        probe("transp",  110, 60, 'h123, 1'b1, 'h123, 0);

        // 3: mirrored
        place(100, 50, 1'b1);
        probe("m_left",  100, 60, 'h456, 1'b1, 'h2FB, 1);
        probe("m_right", 163, 60, 'h456, 1'b1, 'h208, 1);
        probe("m_in",    160, 60, 'h456, 1'b1, 'h20B, 1);

        // 5: right-edge clipping and frame-latched position
        place(1000, 50, 1'b0);
        probe("e_in",   1003, 60, 'h456, 1'b1, 'h20B, 1);
        probe("e_last", 1023, 60, 'h456, 1'b1, 'h25B, 1);
        probe("e_wrap",    5, 60, 'h456, 1'b1, 'h456, 0);
        player_x = 10'd0;
        probe("e_hold0",   5, 60, 'h456, 1'b1, 'h456, 0);
        probe("e_hold1", 1003, 60, 'h456, 1'b1, 'h20B, 1);
        do_tick();
        probe("e_moved",   5, 60, 'h456, 1'b1, 'h219, 1);

        // 6: hit flash
        place(100, 50, 1'b0);
        set_px(103, 60, 'h456, 1'b1);
        hit_pulse = 1'b1;
        cyc();
        hit_pulse = 1'b0;
        probe("hit_hide", 103, 60, 'h456, 1'b1, 'h456, 0);
        check("hit.flashing", int'(flashing), 1);
        flash_ticks = 0;
        for (int i = 0; i < 31; i++) begin
            if (flashing) flash_ticks++;
            do_tick();
        end
        check("flash_ticks", flash_ticks, 30);
        check("flash_done", int'(flashing), 0);

        set_px(103, 60, 'h456, 1'b1);
        hit_pulse = 1'b1;
        cyc();
        hit_pulse = 1'b0;
        for (int i = 0; i < 3; i++) do_tick();
        probe("cnt27_show", 103, 60, 'h456, 1'b1, 'h20B, 1);
        for (int i = 0; i < 22; i++) do_tick();
        probe("cnt5_hide", 103, 60, 'h456, 1'b1, 'h456, 0);
        hit_pulse = 1'b1;
        frame_tick = 1'b1;
        cyc();
        hit_pulse = 1'b0;
        frame_tick = 1'b0;
        for (int i = 0; i < 29; i++) do_tick();
        check("reload29", int'(flashing), 1);
        do_tick();
        check("reload30", int'(flashing), 0);

        // randomized traffic, including occasional mid-frame resets
        for (int i = 0; i < 4000; i++) begin
            int base;
            base     = int'(player_x);
            reset    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1)
                pixel_x = 10'(base + int'($urandom_range(0, 70)) - 3);
            else
                pixel_x = 10'($urandom);
            pixel_y  = 10'(int'(player_y) + int'($urandom_range(0, 70)) - 3);
            bg_rgb   = 12'($urandom);
            video_on = ($urandom_range(0, 7) != 0);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            frame_tick = ($urandom_range(0, 40) == 0);
            hit_pulse  = ($urandom_range(0, 200) == 0);
            if ($urandom_range(0, 60) == 0) begin
                player_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(960, 1023))
                                                       : 10'($urandom);
                player_y = 10'($urandom);
                facing   = 1'($urandom);
            end
            cyc();
        end
        reset = 1'b0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
